regfile_seq: RTL and testbench

Multi-cycle controller that sequences the 8×16 register file and its ALU/shifter datapath. It owns a 16-bit instruction register and decodes MOV-immediate, MOV-register, ADD, CMP, AND and MVN. Per cycle it drives readnum/writenum/write and the datapath load and select strobes. It sits between the instruction source and the datapath, and reports ready on `w`.

---
 rtl/regfile_seq_pkg.sv | 29 ++
 rtl/regfile_seq_instr_dec.sv | 42 ++++
 rtl/regfile_seq.sv | 135 +++++++++++++
 tb/tb_regfile_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the register-file sequencer: state codes, opcode/op fields
// and writeback-source selects.
package regfile_seq_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_EXEC   = 3'd4,
      S_WBACK  = 3'd5,
      S_WIMM   = 3'd6
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // MOV-class op values share the field with the ALU-class op values.
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/regfile_seq_instr_dec.sv
// Combinational instruction decode: field extraction, immediate sign extension and
// instruction-class flags used by the sequencer.
module regfile_seq_instr_dec
   import regfile_seq_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [2:0]  rm,
   output logic [1:0]  op,
   output logic [1:0]  sh,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic        is_movi,
   output logic        is_movr,
   output logic        is_alu2,
   output logic        is_cmp,
   output logic        is_mvn,
   output logic        illegal
);

   logic [2:0] opcode;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign sximm5 = {{11{ir[4]}}, ir[4:0]};

   assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
   assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
   // ADD and AND both read two operands and write Rd, so they share a class.
   assign is_alu2 = (opcode == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
   assign is_cmp  = (opcode == OPC_ALU) && (op == OP_CMP);
   assign is_mvn  = (opcode == OPC_ALU) && (op == OP_MVN);
   assign illegal = !(is_movi || is_movr || is_alu2 || is_cmp || is_mvn);

endmodule

// File: rtl/regfile_seq.sv
// Multi-cycle controller for the 8x16 register file and ALU/shifter datapath:
// holds the instruction register and sequences read, execute and writeback strobes.
module regfile_seq
   import regfile_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic        err,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  vsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   state_t      state, state_nx;
   logic [15:0] ir;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  op;
   logic        is_movi, is_movr, is_alu2, is_cmp, is_mvn, illegal;

   regfile_seq_instr_dec instr_dec (
      .ir      (ir),
      .rn      (rn),
      .rd      (rd),
      .rm      (rm),
      .op      (op),
      .sh      (shift),
      .sximm8  (sximm8),
      .sximm5  (sximm5),
      .is_movi (is_movi),
      .is_movr (is_movr),
      .is_alu2 (is_alu2),
      .is_cmp  (is_cmp),
      .is_mvn  (is_mvn),
      .illegal (illegal)
   );

   // IR captures on the same edge that enters DECODE, so DECODE sees the new word.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      if (!reset_n) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if ((state == S_WAIT) && load) ir <= in;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nx = state;
      w        = 1'b0;
      err      = 1'b0;
      readnum  = rm;
      writenum = rd;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = VSEL_C;
      ALUop    = op;

      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) state_nx = S_DECODE;
         end
         S_DECODE: begin
            if (illegal) begin
               err      = 1'b1;
               state_nx = S_WAIT;
            end else if (is_movi) begin
               state_nx = S_WIMM;
            end else if (is_alu2 || is_cmp) begin
               state_nx = S_GETA;
            end else begin
               state_nx = S_GETB;
            end
         end
         S_GETA: begin
            readnum  = rn;
            loada    = 1'b1;
            state_nx = S_GETB;
         end
         S_GETB: begin
            readnum  = rm;
            loadb    = 1'b1;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            // Single-operand ops zero the A input; MOVR then passes B through an add.
            asel = is_movr || is_mvn;
            if (is_movr) ALUop = OP_ADD;
            if (is_cmp) begin
               loads    = 1'b1;
               state_nx = S_WAIT;
            end else begin
               loadc    = 1'b1;
               state_nx = S_WBACK;
            end
         end
         S_WBACK: begin
            writenum = rd;
            write    = 1'b1;
            state_nx = S_WAIT;
         end
         S_WIMM: begin
            writenum = rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
            state_nx = S_WAIT;
         end
         default: state_nx = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: the controller drives a behavioural regfile/datapath,
// and each instruction's latency, strobes and architectural result are checked.
module tb_regfile_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in;
   logic        load, s;
   logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm8, sximm5;

   int n_cmp  = 0;
   int n_fail = 0;

   regfile_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (in),
      .load     (load),
      .s        (s),
      .w        (w),
      .err      (err),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .shift    (shift),
      .ALUop    (ALUop),
      .sximm8   (sximm8),
      .sximm5   (sximm5)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- environment: strobe-driven regfile and datapath ----------------
   logic [15:0] rf [8];
   logic [15:0] a_reg, b_reg, c_reg, ain, bin, b_sh, alu;
   logic        z_flag;

   always_comb begin
      case (shift)
         2'b00:   b_sh = b_reg;
         2'b01:   b_sh = {b_reg[14:0], 1'b0};
         2'b10:   b_sh = {1'b0, b_reg[15:1]};
         default: b_sh = {b_reg[15], b_reg[15:1]};
      endcase
      ain = asel ? 16'h0000 : a_reg;
      bin = bsel ? sximm5 : b_sh;
      case (ALUop)
         2'b00:   alu = ain + bin;
         2'b01:   alu = ain - bin;
         2'b10:   alu = ain & bin;
         default: alu = ~bin;
      endcase
   end

   always @(posedge clk) begin
      if (write) rf[writenum] <= (vsel == 2'b10) ? sximm8 : c_reg;
      if (loada) a_reg <= rf[readnum];
      if (loadb) b_reg <= rf[readnum];
      if (loadc) c_reg <= alu;
      if (loads) z_flag <= (alu == 16'h0000);
   end

   // ---------------- reference model: architectural effect of one instruction -------
   typedef struct {
      int          lat;
      int          nwr;
      int          nerr;
      logic [2:0]  dst;
      logic [15:0] val;
      bit          chk_z;
      bit          z;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_rf [8];

   function automatic logic [15:0] shifted(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         2'd0:    return v;
         2'd1:    return v << 1;
         2'd2:    return v >> 1;
         default: return 16'($signed(v) >>> 1);
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] ir);
      exp_t        e;
      logic [15:0] bv;
      logic [2:0]  rn, rd;
      rn = ir[10:8];
      rd = ir[7:5];
      bv = shifted(m_rf[ir[2:0]], ir[4:3]);
      e = '{lat: 2, nwr: 0, nerr: 1, dst: 3'd0, val: 16'h0, chk_z: 1'b0, z: 1'b0};
      if (ir[15:11] == 5'b11010) begin
         e = '{lat: 3, nwr: 1, nerr: 0, dst: rn, val: 16'($signed(ir[7:0])), chk_z: 1'b0, z: 1'b0};
      end else if (ir[15:11] == 5'b11000) begin
         e = '{lat: 5, nwr: 1, nerr: 0, dst: rd, val: bv, chk_z: 1'b0, z: 1'b0};
      end else if (ir[15:13] == 3'b101) begin
         case (ir[12:11])
            2'b00:   e = '{lat: 6, nwr: 1, nerr: 0, dst: rd, val: m_rf[rn] + bv, chk_z: 1'b0, z: 1'b0};
            2'b01:   e = '{lat: 5, nwr: 0, nerr: 0, dst: rd, val: 16'h0, chk_z: 1'b1, z: (m_rf[rn] == bv)};
            2'b10:   e = '{lat: 6, nwr: 1, nerr: 0, dst: rd, val: m_rf[rn] & bv, chk_z: 1'b0, z: 1'b0};
            default: e = '{lat: 5, nwr: 1, nerr: 0, dst: rd, val: ~bv, chk_z: 1'b0, z: 1'b0};
         endcase
      end
      if (e.nwr != 0) m_rf[e.dst] = e.val;
      return e;
   endfunction

   // ---------------- monitor: observes each busy window and scores it ----------------
   bit         busy = 1'b0;
   int         cnt, wr_cnt, err_cnt;
   logic [2:0] wr_num;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n !== 1'b1) begin
            busy = 1'b0;
         end else begin
            if (busy) begin
               cnt++;
               if (write) begin
                  wr_cnt++;
                  wr_num = writenum;
               end
               if (err) err_cnt++;
               if (w || cnt > 40) begin
                  busy = 1'b0;
                  check("txn_expected", sb.size() > 0, 1);
                  if (sb.size() > 0) begin
                     e = sb.pop_front();
                     check("latency", cnt, e.lat);
                     check("write_pulses", wr_cnt, e.nwr);
                     check("err_pulses", err_cnt, e.nerr);
                     if (e.nwr != 0) begin
                        check("writenum", wr_num, e.dst);
                        check("reg_value", rf[e.dst], e.val);
                     end
                     if (e.chk_z) check("cmp_zflag", z_flag, e.z);
                  end
               end
            end
            if (!busy && w && s) begin
               busy    = 1'b1;
               cnt     = 0;
               wr_cnt  = 0;
               err_cnt = 0;
               wr_num  = 3'd0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [15:0] instr, input bit split_load);
      exp_t e;
      if (split_load) begin
         load = 1'b1; s = 1'b0; in = instr;
         @(posedge clk); #1;
         load = 1'b0; s = 1'b1; in = 16'($urandom);
      end else begin
         load = 1'b1; s = 1'b1; in = instr;
      end
      e = model(instr);
      sb.push_back(e);
      @(posedge clk); #1;
      // Inputs are junk while busy; the controller must ignore them.
      for (int k = 1; k < e.lat; k++) begin
         load = 1'($urandom); s = 1'($urandom); in = 16'($urandom);
         @(posedge clk); #1;
      end
      load = 1'b0; s = 1'b0; in = 16'($urandom);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 9))
         0, 1: r[15:11] = 5'b11010;
         2:    r[15:11] = 5'b11000;
         8: begin
            if (r[15:13] == 3'b110 || r[15:13] == 3'b101) r[15:13] = 3'b111;
         end
         9:    r[15:11] = {3'b110, r[12], 1'b1};
         default: begin
            r[15:13] = 3'b101;
            if ($urandom_range(0, 2) == 0) begin
               r[2:0] = r[10:8];
               r[4:3] = 2'b00;
            end
         end
      endcase
      return r;
   endfunction

   initial begin
      reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_w", w, 1);
      check("rst_err", err, 0);
      check("rst_strobes", {write, loada, loadb, loadc, loads, asel, bsel}, 0);
      check("rst_readnum", readnum, 0);
      check("rst_writenum", writenum, 0);
      check("rst_vsel", vsel, 0);
      check("rst_ir", {sximm8, shift, ALUop}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) issue({5'b11010, 3'(i), 8'($urandom)}, 1'b0);

      issue(16'hD007, 1'b0);
      issue(16'hD102, 1'b1);
      issue(16'hA148, 1'b0);
      issue(16'hD3FF, 1'b0);
      issue(16'hA900, 1'b1);
      issue(16'hC0E1, 1'b0);
      issue(16'hB8A2, 1'b0);
      issue(16'hE000, 1'b0);
      issue(16'hD800, 1'b0);

      repeat (150) begin
         issue(rand_instr(), 1'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      // Abort an ADD with reset while it sits in GETB.
      load = 1'b1; s = 1'b1; in = 16'hA148;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_getb_loadb", loadb, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("abort_w", w, 1);
      check("abort_loadb", loadb, 0);
      check("abort_write", write, 0);
      check("abort_ir", {sximm8, shift, ALUop}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      repeat (12) issue(rand_instr(), 1'($urandom));

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
